// File: rtl/riscv_pkg.sv
// Shared RV32I constants used by the pipeline front end and decoder:
// widths, reset vector, NOP encoding, major opcodes and fetch FSM states.
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_DRAIN = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head word is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: the storage array has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, keeps up to QDEPTH imem requests in
// flight, buffers returned words and feeds the IF/ID register for decode.
module fetch_stage #(
   parameter int               XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
   parameter int               QDEPTH   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_e,
   input  logic [XLEN-1:0]  redirect_pc_e,
   input  logic             stall_d,
   output logic [31:0]      instr_d,
   output logic [XLEN-1:0]  pc_d,
   output logic [XLEN-1:0]  pcplus4_d,
   output logic             valid_d
);

   import riscv_pkg::*;

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int QW = 32 + XLEN;

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_f_q, pc_f_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [31:0]     instr_d_q;
   logic [XLEN-1:0] pc_d_q, pcplus4_d_q;
   logic            valid_d_q;

   logic [XLEN-1:0] redirect_pc_al;
   logic            req_fire, rsp_keep, bypass, q_push, q_pop;
   logic [QW-1:0]   q_head;
   logic [31:0]     q_instr;
   logic [XLEN-1:0] q_pc;
   logic [CW-1:0]   q_count;
   logic            q_empty, q_full;
   logic [XLEN-1:0] tag_head;
   logic [CW-1:0]   tag_count;
   logic            tag_empty, tag_full;

   assign redirect_pc_al = redirect_pc_e & ~XLEN'(3);

   // In-flight requests plus buffered words never exceed QDEPTH, so the queue cannot overflow.
   assign imem_req_valid = rst_n && (state_q == FETCH_RUN) && !redirect_e &&
                           (({1'b0, outstanding_q} + {1'b0, q_count}) < (CW+1)'(QDEPTH));
   assign imem_addr      = pc_f_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Words still owed to an abandoned path are swallowed while drop_q is non-zero.
   assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_e;
   assign bypass   = rsp_keep && q_empty && !stall_d;
   assign q_push   = rsp_keep && !bypass;
   assign q_pop    = !redirect_e && !stall_d && !q_empty;

   assign q_instr = q_head[QW-1:XLEN];
   assign q_pc    = q_head[XLEN-1:0];

   fetch_queue #(.WIDTH(QW), .DEPTH(QDEPTH)) u_instr_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (q_push),
      .data_i  ({imem_rsp_data, tag_head}),
      .pop_i   (q_pop),
      .flush_i (redirect_e),
      .head_o  (q_head),
      .count_o (q_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   // Tag FIFO carries the PC of each live request; flushed with the path on redirect.
   fetch_queue #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_fire),
      .data_i  (pc_f_q),
      .pop_i   (rsp_keep),
      .flush_i (redirect_e),
      .head_o  (tag_head),
      .count_o (tag_count),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );

   always_comb begin
      // NOTE: every variable gets a default at the top so this block cannot infer a latch.
      pc_f_d        = pc_f_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_e) begin
         pc_f_d = redirect_pc_al;
         drop_d = outstanding_d;
      end else begin
         if (req_fire) pc_f_d = pc_f_q + XLEN'(4);
         if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q       <= FETCH_RUN;
         pc_f_q        <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_f_q        <= pc_f_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         case (state_q)
            FETCH_RUN:   if (redirect_e && (drop_d != '0)) state_q <= FETCH_DRAIN;
            FETCH_DRAIN: if (drop_d == '0) state_q <= FETCH_RUN;
            default:     state_q <= FETCH_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_d_q   <= NOP_INSTR;
         pc_d_q      <= '0;
         pcplus4_d_q <= '0;
         valid_d_q   <= 1'b0;
      end else if (redirect_e) begin
         instr_d_q <= NOP_INSTR;
         valid_d_q <= 1'b0;
      end else if (!stall_d) begin
         if (!q_empty) begin
            instr_d_q   <= q_instr;
            pc_d_q      <= q_pc;
            pcplus4_d_q <= q_pc + XLEN'(4);
            valid_d_q   <= 1'b1;
         end else if (bypass) begin
            instr_d_q   <= imem_rsp_data;
            pc_d_q      <= tag_head;
            pcplus4_d_q <= tag_head + XLEN'(4);
            valid_d_q   <= 1'b1;
         end else begin
            instr_d_q <= NOP_INSTR;
            valid_d_q <= 1'b0;
         end
      end
   end

   assign instr_d   = instr_d_q;
   assign pc_d      = pc_d_q;
   assign pcplus4_d = pcplus4_d_q;
   assign valid_d   = valid_d_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(q_push && q_full && !q_pop));
   a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_keep && tag_empty));
   a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
      !(req_fire && tag_full));
   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && (outstanding_q == '0)));
   a_tags_track: assert property (@(posedge clk) disable iff (!rst_n)
      (drop_q == '0) |-> (tag_count == outstanding_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order imem model of adjustable latency.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_e = 1'b0;
   logic [31:0] redirect_pc_e = 32'h0;
   logic        stall_d = 1'b0;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_e     (redirect_e),
      .redirect_pc_e  (redirect_pc_e),
      .stall_d        (stall_d),
      .instr_d        (instr_d),
      .pc_d           (pc_d),
      .pcplus4_d      (pcplus4_d),
      .valid_d        (valid_d)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample the handshake before the edge, then advance the imem model.
   task automatic step();
      logic        hs;
      logic        rv;
      logic [31:0] a;
      #1;
      hs = imem_req_valid && imem_req_ready;
      rv = imem_rsp_valid;
      a  = imem_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (rv && pend_addr.size() > 0) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (hs) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat - 1);
      end
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(pend_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (valid_d !== 1'b1 && n < max) begin
         step();
         n++;
      end
      check(tag, {31'h0, valid_d}, 32'h1);
   endtask

   task automatic wait_req(input int max, input string tag);
      int n = 0;
      while (imem_req_valid !== 1'b1 && n < max) begin
         step();
         n++;
      end
      check(tag, {31'h0, imem_req_valid}, 32'h1);
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      check("rst valid_d", {31'h0, valid_d}, 32'h0);
      check("rst instr_d", instr_d, NOP);
      check("rst pc_d", pc_d, 32'h0);
      check("rst pcplus4_d", pcplus4_d, 32'h0);
      check("rst req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst imem_addr", imem_addr, 32'h0);

      // Streaming with 1-cycle imem
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("first req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("first addr", imem_addr, 32'h0);
      step();
      check("fill valid_d", {31'h0, valid_d}, 32'h0);
      check("addr 4", imem_addr, 32'h4);
      step();
      check("first valid_d", {31'h0, valid_d}, 32'h1);
      check("first pc_d", pc_d, 32'h0);
      check("first pcplus4_d", pcplus4_d, 32'h4);
      check("first instr_d", instr_d, word_of(32'h0));
      check("addr 8", imem_addr, 32'h8);
      step();
      check("stream pc_d 4", pc_d, 32'h4);
      step();
      check("stream pc_d 8", pc_d, 32'h8);
      check("stream instr 8", instr_d, word_of(32'h8));

      // Stall three cycles at pc_d = 8
      stall_d = 1'b1;
      step();
      check("stall1 pc_d", pc_d, 32'h8);
      check("stall1 valid_d", {31'h0, valid_d}, 32'h1);
      check("stall1 req stops", {31'h0, imem_req_valid}, 32'h0);
      step();
      check("stall2 pc_d", pc_d, 32'h8);
      check("stall2 req", {31'h0, imem_req_valid}, 32'h0);
      step();
      check("stall3 pc_d", pc_d, 32'h8);
      check("stall3 instr", instr_d, word_of(32'h8));
      stall_d = 1'b0;
      step();
      check("unstall pc_d 12", pc_d, 32'hC);
      check("unstall pcplus4", pcplus4_d, 32'h10);
      step();
      check("unstall pc_d 16", pc_d, 32'h10);
      lat = 2;
      step();
      check("unstall pc_d 20", pc_d, 32'h14);
      check("unstall instr 20", instr_d, word_of(32'h14));
      step();
      check("bubble valid_d", {31'h0, valid_d}, 32'h0);
      check("bubble instr", instr_d, NOP);
      check("bubble pc hold", pc_d, 32'h14);

      // Redirect with two requests outstanding
      redirect_e    = 1'b1;
      redirect_pc_e = 32'h100;
      check("redirect blocks req", {31'h0, imem_req_valid}, 32'h0);
      step();
      redirect_e = 1'b0;
      check("redir valid_d", {31'h0, valid_d}, 32'h0);
      check("redir instr", instr_d, NOP);
      check("drain blocks req", {31'h0, imem_req_valid}, 32'h0);
      step();
      check("drain done req", {31'h0, imem_req_valid}, 32'h1);
      check("drain done addr", imem_addr, 32'h100);
      check("drain no stale D", {31'h0, valid_d}, 32'h0);
      wait_valid(10, "redir wait valid");
      check("redir pc_d", pc_d, 32'h100);
      check("redir instr_d", instr_d, word_of(32'h100));
      check("redir pcplus4", pcplus4_d, 32'h104);

      // Redirect and stall together: flush wins
      stall_d       = 1'b1;
      redirect_e    = 1'b1;
      redirect_pc_e = 32'h200;
      step();
      stall_d    = 1'b0;
      redirect_e = 1'b0;
      check("flushwins valid_d", {31'h0, valid_d}, 32'h0);
      check("flushwins instr", instr_d, NOP);
      wait_valid(12, "flushwins wait");
      check("flushwins pc_d", pc_d, 32'h200);

      // Misaligned redirect while imem is not ready
      lat            = 1;
      redirect_e     = 1'b1;
      redirect_pc_e  = 32'h103;
      imem_req_ready = 1'b0;
      step();
      redirect_e = 1'b0;
      wait_req(12, "notready wait req");
      check("aligned addr", imem_addr, 32'h100);
      for (int i = 0; i < 4; i++) begin
         step();
         check("notready req held", {31'h0, imem_req_valid}, 32'h1);
         check("notready addr held", imem_addr, 32'h100);
         check("notready bubble", {31'h0, valid_d}, 32'h0);
      end
      imem_req_ready = 1'b1;
      wait_valid(10, "ready wait valid");
      check("ready pc_d", pc_d, 32'h100);
      step();
      check("ready next pc_d", pc_d, 32'h104);
      check("ready next valid", {31'h0, valid_d}, 32'h1);

      // Async reset in the middle of a drain
      lat = 3;
      step();
      step();
      step();
      redirect_e    = 1'b1;
      redirect_pc_e = 32'h300;
      step();
      redirect_e = 1'b0;
      check("pre-reset drain", {31'h0, imem_req_valid}, 32'h0);
      #2;
      rst_n = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      #1;
      check("async valid_d", {31'h0, valid_d}, 32'h0);
      check("async instr_d", instr_d, NOP);
      check("async pc_d", pc_d, 32'h0);
      check("async pcplus4_d", pcplus4_d, 32'h0);
      check("async req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("async addr", imem_addr, 32'h0);
      lat = 1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("restart req", {31'h0, imem_req_valid}, 32'h1);
      check("restart addr", imem_addr, 32'h0);
      wait_valid(10, "restart wait valid");
      check("restart pc_d", pc_d, 32'h0);
      check("restart instr", instr_d, word_of(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
